// File: rtl/jtpinpon_romslot.sv
// jtpinpon_romslot: single-word cached ROM responder fetching 16-bit words from SDRAM
module jtpinpon_romslot #(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    output logic          ok,
    output logic [7:0]    dout,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [15:0]   sdram_data
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t        st, st_nx;
    logic          valid, hit, start, fill;
    logic [AW-2:0] tag, req_addr;
    logic [15:0]   data;

    assign hit  = valid && tag == addr[AW-1:1];
    assign ok   = cs && hit && !downloading;
    assign dout = addr[0] ? data[15:8] : data[7:0];

    // next state: a started fetch always runs to completion regardless of cs/addr
    always_comb begin
        st_nx = st;
        start = 1'b0;
        fill  = 1'b0;
        case (st)
            ST_IDLE: if (cs && !hit && !downloading) begin
                start = 1'b1;
                st_nx = ST_REQ;
            end
            ST_REQ:  if (sdram_ack) st_nx = ST_WAIT;
            ST_WAIT: if (data_dst && data_rdy) begin
                fill  = 1'b1;
                st_nx = ST_IDLE;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nx;

    // request side: latch the word address and hold req until the arbiter accepts
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_addr   <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
        end else if (start) begin
            req_addr   <= addr[AW-1:1];
            sdram_addr <= OFFSET + 22'(addr[AW-1:1]);
            sdram_req  <= 1'b1;
        end else if (st == ST_REQ && sdram_ack) begin
            sdram_req  <= 1'b0;
        end

    // cache entry: downloads invalidate continuously, so a fill during one stays invalid
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill) begin
                tag  <= req_addr;
                data <= sdram_data;
            end
            valid <= downloading ? 1'b0 : (fill ? 1'b1 : valid);
        end
endmodule

// File: tb/tb_jtpinpon_romslot.sv
// tb_jtpinpon_romslot: scoreboard bench for the ROM slot responder
module tb_jtpinpon_romslot;
    typedef struct {
        string      name;
        logic       ok;
        logic       req;
        logic       care;
        logic [7:0] dout;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [12:0] addr = 13'h0005;
    logic        cs = 1'b1;
    logic        ok;
    logic [7:0]  dout;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic        data_dst = 1'b0;
    logic        data_rdy = 1'b0;
    logic [15:0] sdram_data = 16'h0;

    chk_t        chk_q[$];
    logic [21:0] req_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_req = 1'b0;
    logic        fin_req = 1'b0;
    logic        fin_done = 1'b0;

    jtpinpon_romslot #(.AW(13), .OFFSET(22'h1000)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .addr(addr), .cs(cs),
        .ok(ok), .dout(dout), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
        .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy), .sdram_data(sdram_data)
    );

    always #5 clk = ~clk;

    // monitor: match every request rise and every queued output expectation
    always @(negedge clk) begin
        chk_t        c;
        logic [21:0] e;
        if (sdram_req === 1'b1 && prev_req !== 1'b1) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req sdram_addr=%h required no request", sdram_addr);
            end else begin
                e = req_q.pop_front();
                if (sdram_addr !== e) begin
                    errors++;
                    $display("FAIL req_addr sdram_addr=%h required %h", sdram_addr, e);
                end
            end
        end
        prev_req = sdram_req;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (ok !== c.ok || sdram_req !== c.req || (c.care && dout !== c.dout)) begin
                errors++;
                $display("FAIL %s ok=%b req=%b dout=%h required ok=%b req=%b dout=%h",
                         c.name, ok, sdram_req, dout, c.ok, c.req, c.dout);
            end
        end
        if (fin_req && !fin_done) begin
            checks++;
            if (req_q.size() != 0) begin
                errors++;
                $display("FAIL pending_req outstanding=%0d required 0", req_q.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic o, input logic r, input logic c, input logic [7:0] d);
        chk_t x;
        x.name = n; x.ok = o; x.req = r; x.care = c; x.dout = d;
        chk_q.push_back(x);
    endtask

    task automatic ack_now();
        sdram_ack = 1'b1;
        step(1);
        sdram_ack = 1'b0;
    endtask

    task automatic give_data(input logic dst, input logic [15:0] d);
        data_dst = dst; data_rdy = 1'b1; sdram_data = d;
        step(1);
        data_dst = 1'b0; data_rdy = 1'b0;
    endtask

    initial begin
        step(2);
        expect_out("reset_hold", 1'b0, 1'b0, 1'b1, 8'h00);
        step(1);
        req_q.push_back(22'h1002);
        rst_n = 1'b1;
        step(1);
        ack_now();
        give_data(1'b1, 16'h3412);
        expect_out("reset_fetch", 1'b1, 1'b0, 1'b1, 8'h34);
        step(1);

        addr = 13'h00A3;
        req_q.push_back(22'h1051);
        step(1);
        step(2);
        expect_out("miss_req_held", 1'b0, 1'b1, 1'b0, 8'h00);
        step(1);
        ack_now();
        expect_out("miss_wait", 1'b0, 1'b0, 1'b0, 8'h00);
        give_data(1'b1, 16'hBEEF);
        expect_out("hit_hi", 1'b1, 1'b0, 1'b1, 8'hBE);
        step(1);
        addr = 13'h00A2;
        #1 expect_out("hit_lo", 1'b1, 1'b0, 1'b1, 8'hEF);
        step(3);
        expect_out("hit_lo_hold", 1'b1, 1'b0, 1'b1, 8'hEF);
        step(1);

        addr = 13'h0010;
        req_q.push_back(22'h1008);
        step(1);
        addr = 13'h0200;
        req_q.push_back(22'h1100);
        ack_now();
        give_data(1'b1, 16'hCAFE);
        expect_out("midfetch_nohit", 1'b0, 1'b0, 1'b0, 8'h00);
        step(1);
        addr = 13'h0011;
        #1 expect_out("midfetch_cached", 1'b1, 1'b1, 1'b1, 8'hCA);
        step(1);
        addr = 13'h0200;
        ack_now();
        give_data(1'b1, 16'h0102);
        expect_out("second_fetch", 1'b1, 1'b0, 1'b1, 8'h02);
        step(1);

        addr = 13'h0300;
        req_q.push_back(22'h1180);
        step(1);
        ack_now();
        give_data(1'b0, 16'h1234);
        expect_out("foreign_ignored", 1'b0, 1'b0, 1'b0, 8'h00);
        step(1);
        give_data(1'b1, 16'h5678);
        expect_out("own_data_lo", 1'b1, 1'b0, 1'b1, 8'h78);
        step(1);
        addr = 13'h0301;
        #1 expect_out("own_data_hi", 1'b1, 1'b0, 1'b1, 8'h56);
        step(1);

        downloading = 1'b1;
        #1 expect_out("dl_ok_drop", 1'b0, 1'b0, 1'b0, 8'h00);
        step(4);
        expect_out("dl_no_req", 1'b0, 1'b0, 1'b0, 8'h00);
        step(1);
        downloading = 1'b0;
        req_q.push_back(22'h1180);
        step(1);
        ack_now();
        give_data(1'b1, 16'hABCD);
        expect_out("dl_refetch", 1'b1, 1'b0, 1'b1, 8'hAB);
        step(1);

        addr = 13'h0400;
        req_q.push_back(22'h1200);
        step(1);
        ack_now();
        rst_n = 1'b0;
        cs = 1'b0;
        #1 expect_out("areset_wait", 1'b0, 1'b0, 1'b0, 8'h00);
        step(1);
        cs = 1'b1;
        addr = 13'h0301;
        #1 expect_out("areset_invalid", 1'b0, 1'b0, 1'b0, 8'h00);
        step(1);
        cs = 1'b0;
        rst_n = 1'b1;
        step(1);
        give_data(1'b1, 16'h1111);
        cs = 1'b1;
        addr = 13'h0400;
        #1 expect_out("late_data_ignored", 1'b0, 1'b0, 1'b0, 8'h00);
        req_q.push_back(22'h1200);
        step(1);
        ack_now();
        give_data(1'b1, 16'h2222);
        expect_out("after_reset_fetch", 1'b1, 1'b0, 1'b1, 8'h22);
        step(2);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) step(1);
        if (!fin_done) $fatal(1, "FAIL monitor_stall fin_done=0 required 1");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
